// File: rtl/axi4_sample_ram_slave.sv
// AXI4 responder over on-chip block RAM for the sample recorder/player.
// Independent write and read FSMs; every handshake and payload output is registered.
module axi4_sample_ram_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 24,
    parameter int MEM_DEPTH_LOG2     = 10
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic [2:0]                        S_AXI_AWSIZE,
    input  logic [1:0]                        S_AXI_AWBURST,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [2:0]                        S_AXI_ARSIZE,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int IDX_W  = MEM_DEPTH_LOG2;
    localparam int DEPTH  = 1 << IDX_W;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    function automatic logic [1:0] classify(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr,
                                            input logic [2:0] size,
                                            input logic [1:0] burst);
        if ((addr >> (MEM_DEPTH_LOG2 + 2)) != '0)
            return RESP_DECERR;
        else if (size != 3'b010 || burst[1])
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

    // Byte offset within a word carries no meaning for 32-bit-only beats.
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    logic [1:0]                    r_wstate;
    logic                          r_awready, r_wready, r_bvalid;
    logic [1:0]                    r_bresp, r_wcls;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_bid;
    logic [IDX_W-1:0]              r_widx;
    logic [7:0]                    r_wlen, r_wcnt;
    logic                          r_wfixed, r_wlast_err;

    logic [1:0]                    r_rstate;
    logic                          r_arready, r_rvalid, r_rlast, r_rzero;
    logic [1:0]                    r_rresp;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_rid;
    logic [IDX_W-1:0]              r_ridx;
    logic [7:0]                    r_rlen, r_rcnt;
    logic                          r_rfixed;

    logic                          w_aw_hs, w_w_beat, w_wlast_bad, w_ar_hs, w_mem_we, w_mem_re;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_ram_q;

    assign w_aw_hs     = S_AXI_AWVALID & r_awready;
    assign w_w_beat    = S_AXI_WVALID & r_wready;
    assign w_wlast_bad = S_AXI_WLAST != (r_wcnt == r_wlen);
    assign w_ar_hs     = S_AXI_ARVALID & r_arready;
    assign w_mem_we    = w_w_beat & (r_wcls == RESP_OKAY) & S_AXI_ARESETN;
    assign w_mem_re    = (r_rstate == R_FETCH);

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_wstate    <= W_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_bid       <= '0;
            r_wcls      <= RESP_OKAY;
            r_widx      <= '0;
            r_wlen      <= '0;
            r_wcnt      <= '0;
            r_wfixed    <= 1'b0;
            r_wlast_err <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (w_aw_hs) begin
                        r_bid       <= S_AXI_AWID;
                        r_widx      <= S_AXI_AWADDR[IDX_W+1:2];
                        r_wlen      <= S_AXI_AWLEN;
                        r_wcnt      <= '0;
                        r_wfixed    <= (S_AXI_AWBURST == 2'b00);
                        r_wcls      <= classify(S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWBURST);
                        r_wlast_err <= 1'b0;
                        r_awready   <= 1'b0;
                        r_wready    <= 1'b1;
                        r_wstate    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_beat) begin
                        if (r_wcnt == r_wlen) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_wstate <= W_RESP;
                            // Address decode error outranks any framing problem.
                            if (r_wcls == RESP_DECERR)
                                r_bresp <= RESP_DECERR;
                            else if (r_wcls == RESP_SLVERR || r_wlast_err || w_wlast_bad)
                                r_bresp <= RESP_SLVERR;
                            else
                                r_bresp <= RESP_OKAY;
                        end else begin
                            r_wcnt      <= r_wcnt + 8'd1;
                            r_wlast_err <= r_wlast_err | w_wlast_bad;
                            if (!r_wfixed)
                                r_widx <= r_widx + IDX_W'(1);
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rid     <= '0;
            r_rzero   <= 1'b1;
            r_ridx    <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_rfixed  <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_rid     <= S_AXI_ARID;
                        r_ridx    <= S_AXI_ARADDR[IDX_W+1:2];
                        r_rlen    <= S_AXI_ARLEN;
                        r_rcnt    <= '0;
                        r_rfixed  <= (S_AXI_ARBURST == 2'b00);
                        r_rresp   <= classify(S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST);
                        r_arready <= 1'b0;
                        r_rstate  <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    r_rvalid <= 1'b1;
                    r_rlast  <= (r_rcnt == r_rlen);
                    r_rzero  <= (r_rresp != RESP_OKAY);
                    r_rstate <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        if (r_rcnt == r_rlen) begin
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rcnt   <= r_rcnt + 8'd1;
                            r_rstate <= R_FETCH;
                            if (!r_rfixed)
                                r_ridx <= r_ridx + IDX_W'(1);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // One RAM per byte lane; the read register sees pre-write contents on a same-edge collision.
    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] r_lane [0:DEPTH-1];
            logic [7:0] r_q;
            always_ff @(posedge S_AXI_ACLK) begin
                if (w_mem_we && S_AXI_WSTRB[gi])
                    r_lane[r_widx] <= S_AXI_WDATA[gi*8 +: 8];
                if (w_mem_re)
                    r_q <= r_lane[r_ridx];
            end
            assign w_ram_q[gi*8 +: 8] = r_q;
        end
    endgenerate

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_BID     = r_bid;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RLAST   = r_rlast;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RID     = r_rid;
    assign S_AXI_RDATA   = r_rzero ? '0 : w_ram_q;

endmodule

// File: tb/tb_axi4_sample_ram_slave.sv
// Directed bench for axi4_sample_ram_slave: hand-computed expected values, one line per transaction.
module tb_axi4_sample_ram_slave;

    logic        clk = 1'b0;
    logic        S_AXI_ARESETN;
    logic [0:0]  S_AXI_AWID, S_AXI_ARID, S_AXI_BID, S_AXI_RID;
    logic [23:0] S_AXI_AWADDR, S_AXI_ARADDR;
    logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN;
    logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE;
    logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wd_q [16];
    logic [3:0]  ws_q [16];
    logic [31:0] ex_q [16];

    always #5 clk = ~clk;

    axi4_sample_ram_slave #(
        .C_S_AXI_ID_WIDTH(1), .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(24), .MEM_DEPTH_LOG2(10)
    ) dut (
        .S_AXI_ACLK(clk),             .S_AXI_ARESETN(S_AXI_ARESETN),
        .S_AXI_AWID(S_AXI_AWID),      .S_AXI_AWADDR(S_AXI_AWADDR),
        .S_AXI_AWLEN(S_AXI_AWLEN),    .S_AXI_AWSIZE(S_AXI_AWSIZE),
        .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA),
        .S_AXI_WSTRB(S_AXI_WSTRB),    .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID),  .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID),        .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID),  .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID),      .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARLEN(S_AXI_ARLEN),    .S_AXI_ARSIZE(S_AXI_ARSIZE),
        .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RID(S_AXI_RID),
        .S_AXI_RDATA(S_AXI_RDATA),    .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST),    .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called and returns on a falling edge; data/strobes come from wd_q/ws_q.
    task automatic do_write(input logic [23:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic id, input int bdelay,
                            input bit drop_last, input logic [1:0] exp_resp);
        int t;
        S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
        S_AXI_AWSIZE = size; S_AXI_AWBURST = burst; S_AXI_AWID = id;
        t = 0;
        while (!S_AXI_AWREADY && t < 50) begin @(negedge clk); t++; end
        check_val("awready_wait", 32'(S_AXI_AWREADY), 32'd1);
        @(negedge clk);
        S_AXI_AWVALID = 1'b0;
        check_val("wready_after_aw", 32'(S_AXI_WREADY), 32'd1);
        check_val("awready_low", 32'(S_AXI_AWREADY), 32'd0);
        for (int i = 0; i <= int'(len); i++) begin
            S_AXI_WVALID = 1'b1; S_AXI_WDATA = wd_q[i]; S_AXI_WSTRB = ws_q[i];
            S_AXI_WLAST = (i == int'(len)) && !drop_last;
            @(negedge clk);
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        check_val("bvalid_m1", 32'(S_AXI_BVALID), 32'd1);
        check_val("bresp", 32'(S_AXI_BRESP), 32'(exp_resp));
        check_val("bid", 32'(S_AXI_BID), 32'(id));
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            check_val("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
            check_val("bresp_hold", 32'(S_AXI_BRESP), 32'(exp_resp));
        end
        S_AXI_BREADY = 1'b1;
        @(negedge clk);
        S_AXI_BREADY = 1'b0;
        check_val("bvalid_drop", 32'(S_AXI_BVALID), 32'd0);
        check_val("awready_back", 32'(S_AXI_AWREADY), 32'd1);
        $display("write addr=0x%06h len=%0d size=%0d burst=%0d bresp=%0d", addr, len, size, burst, exp_resp);
    endtask

    // Expected beats come from ex_q; slow=1 holds RREADY low for one cycle on each beat.
    task automatic do_read(input logic [23:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic id, input logic [1:0] exp_resp,
                           input bit slow);
        int t;
        S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = addr; S_AXI_ARLEN = len;
        S_AXI_ARSIZE = size; S_AXI_ARBURST = burst; S_AXI_ARID = id;
        t = 0;
        while (!S_AXI_ARREADY && t < 50) begin @(negedge clk); t++; end
        check_val("arready_wait", 32'(S_AXI_ARREADY), 32'd1);
        @(negedge clk);
        S_AXI_ARVALID = 1'b0;
        check_val("arready_low", 32'(S_AXI_ARREADY), 32'd0);
        for (int i = 0; i <= int'(len); i++) begin
            check_val("rvalid_gap", 32'(S_AXI_RVALID), 32'd0);
            @(negedge clk);
            check_val("rvalid_2cyc", 32'(S_AXI_RVALID), 32'd1);
            check_val("rdata", S_AXI_RDATA, ex_q[i]);
            check_val("rresp", 32'(S_AXI_RRESP), 32'(exp_resp));
            check_val("rlast", 32'(S_AXI_RLAST), 32'(i == int'(len)));
            check_val("rid", 32'(S_AXI_RID), 32'(id));
            if (slow) begin
                @(negedge clk);
                check_val("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
                check_val("rdata_hold", S_AXI_RDATA, ex_q[i]);
                check_val("rlast_hold", 32'(S_AXI_RLAST), 32'(i == int'(len)));
            end
            S_AXI_RREADY = 1'b1;
            @(negedge clk);
            S_AXI_RREADY = 1'b0;
        end
        check_val("arready_back", 32'(S_AXI_ARREADY), 32'd1);
        $display("read  addr=0x%06h len=%0d size=%0d burst=%0d rresp=%0d", addr, len, size, burst, exp_resp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        S_AXI_ARESETN = 1'b0;
        S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = 3'b010;
        S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = 3'b010;
        S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check_val("rst_wready",  32'(S_AXI_WREADY),  32'd0);
        check_val("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check_val("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check_val("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        check_val("rst_rlast",   32'(S_AXI_RLAST),   32'd0);
        check_val("rst_bresp",   32'(S_AXI_BRESP),   32'd0);
        check_val("rst_rresp",   32'(S_AXI_RRESP),   32'd0);
        check_val("rst_rdata",   S_AXI_RDATA,        32'd0);
        check_val("rst_bid",     32'(S_AXI_BID),     32'd0);
        check_val("rst_rid",     32'(S_AXI_RID),     32'd0);
        S_AXI_ARESETN = 1'b1;
        @(negedge clk);
        check_val("post_rst_awready", 32'(S_AXI_AWREADY), 32'd1);
        check_val("post_rst_arready", 32'(S_AXI_ARREADY), 32'd1);

        // Single-beat write and read-back
        wd_q[0] = 32'hABCD0000; ws_q[0] = 4'hF;
        do_write(24'h000004, 8'd0, 3'b010, 2'b01, 1'b1, 0, 1'b0, 2'b00);
        ex_q[0] = 32'hABCD0000;
        do_read(24'h000004, 8'd0, 3'b010, 2'b01, 1'b1, 2'b00, 1'b0);

        // INCR burst with partial strobe over an all-ones background
        for (int i = 0; i < 4; i++) begin wd_q[i] = 32'hFFFFFFFF; ws_q[i] = 4'hF; end
        do_write(24'h000010, 8'd3, 3'b010, 2'b01, 1'b0, 0, 1'b0, 2'b00);
        wd_q[0] = 32'd1; wd_q[1] = 32'h00020002; wd_q[2] = 32'd3; wd_q[3] = 32'd4;
        ws_q[1] = 4'hC;
        do_write(24'h000010, 8'd3, 3'b010, 2'b01, 1'b0, 0, 1'b0, 2'b00);
        ex_q[0] = 32'd1; ex_q[1] = 32'h0002FFFF; ex_q[2] = 32'd3; ex_q[3] = 32'd4;
        do_read(24'h000010, 8'd3, 3'b010, 2'b01, 1'b0, 2'b00, 1'b0);

        // Illegal size: two beats still consumed, memory untouched
        wd_q[0] = 32'h12345678; wd_q[1] = 32'h9ABCDEF0; ws_q[0] = 4'hF; ws_q[1] = 4'hF;
        do_write(24'h000004, 8'd1, 3'b101, 2'b01, 1'b0, 0, 1'b0, 2'b10);
        ex_q[0] = 32'hABCD0000;
        do_read(24'h000004, 8'd0, 3'b010, 2'b01, 1'b0, 2'b00, 1'b0);

        // Out-of-range address decodes as DECERR with zero data; illegal burst is SLVERR
        ex_q[0] = 32'd0; ex_q[1] = 32'd0;
        do_read(24'h001000, 8'd1, 3'b010, 2'b01, 1'b1, 2'b11, 1'b0);
        do_read(24'h000004, 8'd0, 3'b010, 2'b10, 1'b0, 2'b10, 1'b0);

        // Missing WLAST: SLVERR but data still lands
        wd_q[0] = 32'h000000AA; wd_q[1] = 32'h000000BB;
        do_write(24'h000040, 8'd1, 3'b010, 2'b01, 1'b1, 0, 1'b1, 2'b10);
        ex_q[0] = 32'h000000AA; ex_q[1] = 32'h000000BB;
        do_read(24'h000040, 8'd1, 3'b010, 2'b01, 1'b1, 2'b00, 1'b0);

        // FIXED burst keeps overwriting one word
        wd_q[0] = 32'd5; wd_q[1] = 32'd6; wd_q[2] = 32'd7; ws_q[2] = 4'hF;
        do_write(24'h000030, 8'd2, 3'b010, 2'b00, 1'b0, 0, 1'b0, 2'b00);
        ex_q[0] = 32'd7; ex_q[1] = 32'd7;
        do_read(24'h000030, 8'd1, 3'b010, 2'b00, 1'b0, 2'b00, 1'b0);

        // INCR wraps from the top word to word 0
        wd_q[0] = 32'hA5A50001; wd_q[1] = 32'hA5A50002;
        do_write(24'h000FFC, 8'd1, 3'b010, 2'b01, 1'b0, 0, 1'b0, 2'b00);
        ex_q[0] = 32'hA5A50002;
        do_read(24'h000000, 8'd0, 3'b010, 2'b01, 1'b0, 2'b00, 1'b0);

        // Backpressure on B and R
        wd_q[0] = 32'hB0; wd_q[1] = 32'hB1; wd_q[2] = 32'hB2;
        do_write(24'h000050, 8'd2, 3'b010, 2'b01, 1'b1, 5, 1'b0, 2'b00);
        ex_q[0] = 32'hB0; ex_q[1] = 32'hB1; ex_q[2] = 32'hB2;
        do_read(24'h000050, 8'd2, 3'b010, 2'b01, 1'b1, 2'b00, 1'b1);

        // Same-word collision: read fetch coincides with the write beat
        wd_q[0] = 32'h11111111;
        do_write(24'h000020, 8'd0, 3'b010, 2'b01, 1'b0, 0, 1'b0, 2'b00);
        @(negedge clk);
        check_val("coll_awready", 32'(S_AXI_AWREADY), 32'd1);
        check_val("coll_arready", 32'(S_AXI_ARREADY), 32'd1);
        S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = 24'h000020; S_AXI_AWLEN = 8'd0; S_AXI_AWID = 1'b1;
        S_AXI_AWSIZE = 3'b010; S_AXI_AWBURST = 2'b01;
        S_AXI_ARVALID = 1'b1; S_AXI_ARADDR = 24'h000020; S_AXI_ARLEN = 8'd0; S_AXI_ARID = 1'b0;
        S_AXI_ARSIZE = 3'b010; S_AXI_ARBURST = 2'b01;
        @(negedge clk);
        S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        S_AXI_WVALID = 1'b1; S_AXI_WDATA = 32'h22222222; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b1;
        @(negedge clk);
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        check_val("coll_rvalid", 32'(S_AXI_RVALID), 32'd1);
        check_val("coll_rdata_old", S_AXI_RDATA, 32'h11111111);
        check_val("coll_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check_val("coll_bresp", 32'(S_AXI_BRESP), 32'd0);
        S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
        @(negedge clk);
        S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
        check_val("coll_rvalid_drop", 32'(S_AXI_RVALID), 32'd0);
        check_val("coll_bvalid_drop", 32'(S_AXI_BVALID), 32'd0);
        $display("concurrent write+read addr=0x000020 read-first");
        ex_q[0] = 32'h22222222;
        do_read(24'h000020, 8'd0, 3'b010, 2'b01, 1'b0, 2'b00, 1'b0);

        // Reset during an 8-beat write after three beats
        S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = 24'h000100; S_AXI_AWLEN = 8'd7; S_AXI_AWID = 1'b0;
        S_AXI_AWSIZE = 3'b010; S_AXI_AWBURST = 2'b01;
        t = 0;
        while (!S_AXI_AWREADY && t < 50) begin @(negedge clk); t++; end
        check_val("mid_awready", 32'(S_AXI_AWREADY), 32'd1);
        @(negedge clk);
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            S_AXI_WVALID = 1'b1; S_AXI_WDATA = 32'hC0DE0000 + 32'(i); S_AXI_WSTRB = 4'hF;
            S_AXI_WLAST = 1'b0;
            @(negedge clk);
        end
        S_AXI_WVALID = 1'b0;
        S_AXI_ARESETN = 1'b0;
        @(negedge clk);
        check_val("mid_rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check_val("mid_rst_wready",  32'(S_AXI_WREADY),  32'd0);
        check_val("mid_rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check_val("mid_rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check_val("mid_rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        S_AXI_ARESETN = 1'b1;
        @(negedge clk);
        check_val("mid_post_awready", 32'(S_AXI_AWREADY), 32'd1);
        check_val("mid_post_wready",  32'(S_AXI_WREADY),  32'd0);
        $display("reset during 8-beat write at addr=0x000100 after 3 beats");
        ex_q[0] = 32'hC0DE0000; ex_q[1] = 32'hC0DE0001; ex_q[2] = 32'hC0DE0002;
        do_read(24'h000100, 8'd2, 3'b010, 2'b01, 1'b0, 2'b00, 1'b0);
        wd_q[0] = 32'h600D600D; ws_q[0] = 4'hF;
        do_write(24'h00010C, 8'd0, 3'b010, 2'b01, 1'b1, 0, 1'b0, 2'b00);
        ex_q[0] = 32'h600D600D;
        do_read(24'h00010C, 8'd0, 3'b010, 2'b01, 1'b1, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
